// File: rtl/riscv_run_ctrl.sv
// Run/halt controller for a single-cycle RISC-V core: reset sequencing, STEP/RUN/RUN_N
// execution control, PC breakpoints and an enabled-cycle counter.
module riscv_run_ctrl #(
    parameter int CNT_W    = 32,
    parameter int PC_W     = 32,
    parameter int NUM_BP   = 2,
    parameter int RST_HOLD = 4
) (
    input  logic                                            clock,
    input  logic                                            rst,
    input  logic                                            cmd_valid,
    output logic                                            cmd_ready,
    input  logic [1:0]                                      cmd_op,
    input  logic [CNT_W-1:0]                                cmd_count,
    input  logic                                            bp_wr,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0]  bp_idx,
    input  logic [PC_W-1:0]                                 bp_addr,
    input  logic                                            bp_en,
    input  logic [PC_W-1:0]                                 core_pc,
    output logic                                            core_rst,
    output logic                                            core_clk_en,
    output logic                                            halted,
    output logic [1:0]                                      halt_cause,
    output logic [CNT_W-1:0]                                cycle_count
);

    localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_STEP  = 2'd1;
    localparam logic [1:0] CAUSE_COUNT = 2'd2;
    localparam logic [1:0] CAUSE_BP    = 2'd3;

    typedef enum logic [2:0] {
        RST_SEQ,
        HALT,
        STEP,
        RUN,
        RUN_N
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_skip_bp;
    logic [1:0]          r_cause;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [NUM_BP-1:0]   r_bp_en;
    logic [PC_W-1:0]     r_bp_addr [NUM_BP];

    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [CNT_W-1:0]    w_remaining_nxt;
    logic                w_skip_nxt;
    logic [1:0]          w_cause_nxt;
    logic                w_bp_match;
    logic                w_running;
    logic                w_accept;
    logic                w_stop;
    logic                w_bp_hit;
    logic                w_clk_en;
    logic                w_cmd_ready;

    always_comb begin
        w_bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (r_bp_en[i] && (r_bp_addr[i] == core_pc)) begin
                w_bp_match = 1'b1;
            end
        end
    end

    // Stop and breakpoint gate the core enable combinationally so the offending cycle never executes.
    always_comb begin
        w_cmd_ready = (r_state != RST_SEQ);
        w_running   = (r_state == STEP) || (r_state == RUN) || (r_state == RUN_N);
        w_accept    = cmd_valid && w_cmd_ready;
        w_stop      = w_accept && (cmd_op == OP_STOP) && w_running;
        w_bp_hit    = ((r_state == RUN) || (r_state == RUN_N)) && !r_skip_bp && w_bp_match;
        w_clk_en    = w_running && !w_stop && !w_bp_hit;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_remaining_nxt = r_remaining;
        w_skip_nxt      = 1'b0;
        w_cause_nxt     = r_cause;
        case (r_state)
            RST_SEQ: begin
                if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_NONE;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            HALT: begin
                if (w_accept) begin
                    w_cause_nxt = CAUSE_NONE;
                    case (cmd_op)
                        OP_STEP: w_state_nxt = STEP;
                        OP_RUN: begin
                            w_state_nxt = RUN;
                            w_skip_nxt  = 1'b1;
                        end
                        OP_RUN_N: begin
                            if (cmd_count != '0) begin
                                w_state_nxt     = RUN_N;
                                w_remaining_nxt = cmd_count;
                                w_skip_nxt      = 1'b1;
                            end
                        end
                        default: w_state_nxt = HALT;
                    endcase
                end
            end
            STEP: begin
                w_state_nxt = HALT;
                w_cause_nxt = w_stop ? CAUSE_NONE : CAUSE_STEP;
            end
            RUN: begin
                if (w_stop) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_NONE;
                end else if (w_bp_hit) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_BP;
                end
            end
            RUN_N: begin
                if (w_stop) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_NONE;
                end else if (w_bp_hit) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_BP;
                end else if (r_remaining == CNT_W'(1)) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = CAUSE_COUNT;
                end else begin
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                end
            end
            default: w_state_nxt = RST_SEQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state     <= RST_SEQ;
            r_hold_cnt  <= '0;
            r_remaining <= '0;
            r_skip_bp   <= 1'b0;
            r_cause     <= CAUSE_NONE;
            r_cycle_cnt <= '0;
            r_bp_en     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_remaining <= w_remaining_nxt;
            r_skip_bp   <= w_skip_nxt;
            r_cause     <= w_cause_nxt;
            if (w_clk_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr && (bp_idx == IDX_W'(i))) begin
                    r_bp_en[i] <= bp_en;
                end
            end
        end
    end

    // Breakpoint addresses are qualified by their enables, so they need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_wr && (bp_idx == IDX_W'(i))) begin
                r_bp_addr[i] <= bp_addr;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign core_rst    = (r_state == RST_SEQ);
    assign core_clk_en = w_clk_en;
    assign halted      = (r_state == HALT);
    assign halt_cause  = r_cause;
    assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: a command-level model predicts each halt
// (cause, cycle_count, core PC); a monitor compares on every halt event.
module tb_riscv_run_ctrl;

    localparam int CNT_W    = 32;
    localparam int PC_W     = 32;
    localparam int NUM_BP   = 2;
    localparam int RST_HOLD = 4;

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             bp_wr = 1'b0;
    logic [0:0]       bp_idx = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic             bp_en = 1'b0;
    logic [PC_W-1:0]  core_pc = '0;
    logic             core_rst;
    logic             core_clk_en;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_count;

    riscv_run_ctrl #(
        .CNT_W(CNT_W), .PC_W(PC_W), .NUM_BP(NUM_BP), .RST_HOLD(RST_HOLD)
    ) dut (
        .clock(clock), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
        .core_pc(core_pc), .core_rst(core_rst), .core_clk_en(core_clk_en),
        .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Simple core: PC advances by 4 on every enabled cycle.
    always @(posedge clock) begin
        if (core_rst) core_pc <= '0;
        else if (core_clk_en) core_pc <= core_pc + 32'd4;
    end

    typedef struct packed {
        logic [1:0]  cause;
        logic [31:0] cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [31:0] m_pc = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_bp_addr [NUM_BP];
    logic        m_bp_en [NUM_BP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic m_inbp(input logic [31:0] pc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (m_bp_en[i] && (m_bp_addr[i] == pc)) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic check_event();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_halt: cause=%0d cycle_count=%0d pc=%0h, required no halt event",
                     halt_cause, cycle_count, core_pc);
        end else begin
            e = exp_q.pop_front();
            chk("halt_cause", 64'(halt_cause), 64'(e.cause));
            chk("cycle_count", 64'(cycle_count), 64'(e.cyc));
            chk("core_pc_at_halt", 64'(core_pc), 64'(e.pc));
        end
    endtask

    // Monitor: a halt event is entering HALT, or staying in HALT after an accepted command.
    logic acc_halt = 1'b0;
    logic prev_halted = 1'b0;

    always @(posedge clock) begin
        acc_halt <= cmd_valid && cmd_ready && halted;
    end

    always @(negedge clock) begin
        if (halted === 1'b1 && (prev_halted !== 1'b1 || acc_halt)) check_event();
        prev_halted <= halted;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic bp_write(input int idx, input logic [31:0] addr, input logic en);
        bp_wr   = 1'b1;
        bp_idx  = 1'(idx);
        bp_addr = addr;
        bp_en   = en;
        tick();
        bp_wr = 1'b0;
        m_bp_addr[idx] = addr;
        m_bp_en[idx]   = en;
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (halted !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, n);
        end
    endtask

    // Command-level prediction: cycle i of a run executes the PC at pc0+4*(i-1).
    task automatic model_cmd(input logic [1:0] op, input int cnt, input int stop_at, output bit stopped);
        logic [31:0] pc;
        logic [1:0]  cause;
        int          en;
        pc = m_pc;
        cause = 2'd0;
        en = 0;
        stopped = 1'b0;
        if (op == OP_STEP) begin
            en = 1;
            cause = 2'd1;
        end else if (op == OP_RUN || (op == OP_RUN_N && cnt > 0)) begin
            for (int i = 1; i <= 5000; i++) begin
                if (stop_at == i) begin
                    cause = 2'd0; en = i - 1; stopped = 1'b1;
                    break;
                end
                if (i >= 2 && m_inbp(pc)) begin
                    cause = 2'd3; en = i - 1;
                    break;
                end
                if (op == OP_RUN_N && i == cnt) begin
                    cause = 2'd2; en = i;
                    break;
                end
                pc = pc + 32'd4;
            end
        end
        m_pc  = m_pc + 32'(4 * en);
        m_cyc = m_cyc + 32'(en);
        exp_q.push_back('{cause: cause, cyc: m_cyc, pc: m_pc});
    endtask

    task automatic run_cmd(input logic [1:0] op, input int cnt, input int stop_at);
        bit stopped;
        model_cmd(op, cnt, stop_at, stopped);
        issue(op, 32'(cnt));
        if (stopped) begin
            repeat (stop_at - 1) tick();
            issue(OP_STOP, 32'd0);
        end
        wait_halt();
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b0;
        tick();
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_halt_cause", 64'(halt_cause), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_core_clk_en", 64'(core_clk_en), 64'd0);
        repeat (2) tick();
        m_pc  = '0;
        m_cyc = '0;
        for (int i = 0; i < NUM_BP; i++) m_bp_en[i] = 1'b0;
        exp_q.push_back('{cause: 2'd0, cyc: 32'd0, pc: 32'd0});
        rst = 1'b1;
        n = 0;
        while (core_rst === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk("rst_hold_cycles", 64'(n), 64'(RST_HOLD));
    endtask

    initial begin
        for (int i = 0; i < NUM_BP; i++) begin
            m_bp_addr[i] = '0;
            m_bp_en[i]   = 1'b0;
        end

        do_reset();
        run_cmd(OP_STEP, 0, 0);
        run_cmd(OP_STEP, 0, 0);
        run_cmd(OP_STEP, 0, 0);
        run_cmd(OP_RUN_N, 10, 0);
        run_cmd(OP_RUN_N, 0, 0);

        do_reset();
        bp_write(0, 32'h10, 1'b1);
        run_cmd(OP_RUN, 0, 40);
        run_cmd(OP_RUN, 0, 3);
        bp_write(1, m_pc + 32'd8, 1'b1);
        run_cmd(OP_RUN, 0, 3);
        bp_write(1, m_pc + 32'd12, 1'b1);
        run_cmd(OP_RUN_N, 4, 0);
        run_cmd(OP_STEP, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 1) begin
                bp_write(int'($urandom_range(0, 1)), m_pc + 32'(4 * $urandom_range(0, 10)),
                         1'($urandom_range(0, 1)));
            end else if (r == 2) begin
                run_cmd(OP_STEP, 0, 0);
            end else if (r == 3) begin
                run_cmd(OP_STOP, 0, 0);
            end else if (r <= 6) begin
                run_cmd(OP_RUN, 0, int'($urandom_range(1, 14)));
            end else begin
                run_cmd(OP_RUN_N, int'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0);
            end
        end

        // Abort a RUN_N with 5 cycles left; enables must clear so 0x10 no longer stops a run.
        bp_write(0, 32'h10, 1'b1);
        bp_write(1, 32'h14, 1'b1);
        issue(OP_RUN_N, 32'd20);
        repeat (15) tick();
        do_reset();
        run_cmd(OP_RUN, 0, 8);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the run-count and cycle counters.
REQ-002 Parameter PC_W, default 32, width of the program counter.
REQ-003 Parameter NUM_BP, default 2, number of PC breakpoint comparators (1..8).
REQ-004 Parameter RST_HOLD, default 4, number of cycles the core reset is held (>=1).
REQ-005 Port clock  in  1  single clock; every flop is rising-edge.
REQ-006 Port rst  in  1  reset, synchronous, active-low.
REQ-007 Port cmd_valid  in  1  command offered.
REQ-008 Port cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-009 Port cmd_op  in  2  command: 0 STOP, 1 STEP, 2 RUN, 3 RUN_N.
REQ-010 Port cmd_count  in  CNT_W  cycle count for RUN_N.
REQ-011 Port bp_wr  in  1  breakpoint write strobe.
REQ-012 Port bp_idx  in  clog2(NUM_BP) (min 1)  breakpoint slot.
REQ-013 Port bp_addr  in  PC_W  breakpoint PC.
REQ-014 Port bp_en  in  1  slot enable written with bp_addr.
REQ-015 Port core_pc  in  PC_W  current PC of the single-cycle core.
REQ-016 Port core_rst  out  1  active-high reset to the core.
REQ-017 Port core_clk_en  out  1  core advances one instruction on each clock where this is 1.
REQ-018 Port halted  out  1  controller in HALT.
REQ-019 Port halt_cause  out  2  0 none/STOP, 1 step done, 2 count done, 3 breakpoint.
REQ-020 Port cycle_count  out  CNT_W  total enabled core cycles since reset, wraps.

Function
REQ-021 States SHALL be RST_SEQ, HALT, STEP, RUN, RUN_N.
REQ-022 RST_SEQ: core_rst=1, core_clk_en=0, cmd_ready=0; after RST_HOLD cycles, move to HALT with halt_cause=0.
REQ-023 HALT: cmd_ready=1, core_clk_en=0; accepted STEP -> STEP; RUN -> RUN; RUN_N with cmd_count>0 -> RUN_N, loading the remaining counter; RUN_N with count 0 or STOP -> stay HALT, halt_cause=0.
REQ-024 STEP: core_clk_en=1 for exactly one cycle, then HALT with halt_cause=1.
REQ-025 RUN: core_clk_en=1 every cycle until an accepted STOP or a breakpoint hit.
REQ-026 RUN_N: core_clk_en=1 and remaining decrements each cycle; in the cycle remaining==1, go to HALT with halt_cause=2 after exactly cmd_count enabled cycles.
REQ-027 In STEP/RUN/RUN_N, cmd_ready=1 but only STOP is acted on; other ops are accepted and dropped.
REQ-028 An accepted STOP SHALL deassert core_clk_en in the same cycle (combinational) and enter HALT with halt_cause=0.
REQ-029 Breakpoint hit: an enabled slot with bp_addr==core_pc while in RUN or RUN_N; core_clk_en SHALL be 0 that cycle (the instruction at the PC does not execute); next state HALT, halt_cause=3.
REQ-030 Breakpoints SHALL NOT apply in STEP, so a STEP always leaves a breakpoint PC.
REQ-031 Leaving HALT by RUN/RUN_N with core_pc already at an enabled breakpoint: the first cycle SHALL ignore breakpoints (skip-once).
REQ-032 Priority in the same cycle: STOP > breakpoint > count-done.
REQ-033 A bp_wr SHALL take effect from the next cycle; a write in any state is allowed.
REQ-034 cycle_count SHALL increment on every cycle with core_clk_en=1, wrap to 0 at 2^CNT_W.
REQ-035 halted=1 exactly in HALT; halt_cause holds until the next exit from HALT, then clears to 0.

Reset
REQ-036 With rst=0 at a clock edge: state RST_SEQ, hold counter restarts, core_rst=1, core_clk_en=0, cmd_ready=0, halted=0, halt_cause=0, cycle_count=0, remaining=0, all breakpoint enables 0.
REQ-037 rst asserted mid-RUN or mid-RUN_N SHALL abort the run, and the full RST_HOLD sequence SHALL restart after release.

Verification
REQ-038 Release reset with RST_HOLD=4 -> core_rst=1 for 4 cycles, then halted=1, halt_cause=0, cycle_count=0.
REQ-039 Three STEP commands -> three single-cycle core_clk_en pulses, cycle_count=3, halt_cause=1 after each.
REQ-040 RUN_N with cmd_count=10 -> exactly 10 enabled cycles, halted with halt_cause=2, cycle_count +10; RUN_N with count=0 -> no enable, halt_cause=0.
REQ-041 bp slot0=0x0000_0010 enabled, RUN from PC 0 with a PC incremented by 4 -> 4 enabled cycles, halt at core_pc=0x10, halt_cause=3; RUN again -> passes 0x10 (skip-once).
REQ-042 Breakpoint match and STOP in the same cycle -> halt_cause=0; RUN_N remaining==1 and breakpoint in the same cycle -> halt_cause=3, core_clk_en=0.
REQ-043 rst=0 mid-RUN_N (remaining 5) -> next cycle core_rst=1, cycle_count=0, breakpoints cleared, RST_SEQ restarts.
